// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem and buffers {pc, instr} in a prefetch FIFO.
// Optional MISALIGN_TRAP_EN: odd redirect targets are rejected and set a sticky misalign_err instead of being aligned.
module ifetch_ctrl #(
  parameter int               ADDR_W     = 16,
  parameter int               INSTR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic               misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [PTR_W-1:0]    rptr, wptr;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   fifo_pc    [FIFO_DEPTH];
  logic [INSTR_W-1:0]  fifo_instr [FIFO_DEPTH];
  logic                pop, push, redir, trap;
  logic [ADDR_W-1:0]   redirect_target;

  assign imem_addr       = pc;
  assign out_valid       = (count != '0);
  assign out_instr       = fifo_instr[rptr];
  assign out_pc          = fifo_pc[rptr];
  assign halted          = (state == HALTED);
  assign redirect_target = redirect_pc & ~ADDR_W'(1);

  always_comb begin
    trap      = 1'b0;
    redir     = 1'b0;
    push      = 1'b0;
    pop       = out_valid && out_ready;
    state_nxt = state;
`ifdef MISALIGN_TRAP_EN
    // An odd target is swallowed entirely: the cycle behaves as if no redirect arrived.
    trap = redirect_valid && (state != BOOT) && redirect_pc[0];
`endif
    if (state == BOOT) begin
      state_nxt = RUN;
    end else if (redirect_valid && !trap) begin
      redir     = 1'b1;
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (halt_req) state_nxt = HALTED;
      else          push = (count < CNT_W'(FIFO_DEPTH)) || pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (redir) begin
        pc    <= redirect_target;
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          fifo_pc[wptr]    <= pc;
          fifo_instr[wptr] <= imem_instr;
          wptr             <= wptr + PTR_W'(1);
          pc               <= pc + ADDR_W'(2);
        end
        if (pop) rptr <= rptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err_q <= 1'b0;
    else if (trap) err_q <= 1'b1;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed vector table, hand sequences and a random run against a queue-based model.
module tb_ifetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr, imem_instr;
  logic        halt_req = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid, halted, misalign_err;
  logic [15:0] out_instr, out_pc;

  int checks = 0;
  int errors = 0;

  ifetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .halt_req(halt_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference model: a queue of {pc, instr}; mode 0 = just out of reset, 1 = fetching, 2 = halted.
  logic [31:0] mq[$];
  logic [15:0] m_pc;
  int          m_mode;
  logic        m_err;

  task automatic model_reset();
    mq.delete();
    m_pc   = 16'h0000;
    m_mode = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic rv, input logic [15:0] rpc, input logic rdy);
    int  sz;
    bit  take, odd_rej;
    sz      = mq.size();
    take    = (sz > 0) && rdy;
    odd_rej = TRAP && rv && rpc[0] && (m_mode != 0);
    if (odd_rej) m_err = 1'b1;
    if (m_mode == 0) begin
      m_mode = 1;
      if (take) void'(mq.pop_front());
    end else if (rv && !odd_rej) begin
      mq.delete();
      m_pc   = {rpc[15:1], 1'b0};
      m_mode = 1;
    end else begin
      if (take) void'(mq.pop_front());
      if (m_mode == 1 && h) m_mode = 2;
      else if (m_mode == 1 && (sz < DEPTH || take)) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("m_pc",    32'(out_pc),    32'(mq[0][31:16]));
      check("m_instr", 32'(out_instr), 32'(mq[0][15:0]));
    end
    check("m_imem_addr", 32'(imem_addr), 32'(m_pc));
    check("m_halted",    32'(halted),    32'(m_mode == 2));
    check("m_misalign",  32'(misalign_err), 32'(m_err));
  endtask

  task automatic cycle(input logic h, input logic rv, input logic [15:0] rpc, input logic rdy);
    halt_req = h; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    model_step(h, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic expect_head(input string name, input logic v, input logic [15:0] p, input logic [15:0] i);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({name, "_pc"},    32'(out_pc),    32'(p));
      check({name, "_instr"}, 32'(out_instr), 32'(i));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    halt_req = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid",    32'(out_valid),    32'd0);
    check("rst_instr",    32'(out_instr),    32'd0);
    check("rst_pc",       32'(out_pc),       32'd0);
    check("rst_halted",   32'(halted),       32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_addr",     32'(imem_addr),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        h;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] ei;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Each row: inputs for one rising edge, head expected just after it.
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000}; // boot cycle
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h1000};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h1001};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h1002};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h1002}; // fills to 2
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h1002}; // full, no fetch
    tbl[6] = '{1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0000, 16'h0000}; // redirect while full
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1010};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 16'h1011};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0024, 16'h1012};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].h, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      expect_head($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei);
    end

    // Backpressure: pc stalls at 4 with two entries held, then drains in order.
    do_reset();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("bp_addr", 32'(imem_addr), 32'h0004);
    for (int i = 0; i < 3; i++) begin
      expect_head($sformatf("bp%0d", i), 1'b1, 16'(2 * i), 16'(16'h1000 + i));
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
    end

    // Halt at pc 6, drain, then resume via redirect to 0.
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("halt_pre_addr", 32'(imem_addr), 32'h0006);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr", 32'(imem_addr), 32'h0006);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    expect_head("halt_drained", 1'b0, 16'h0, 16'h0);
    check("halt_addr_hold", 32'(imem_addr), 32'h0006);
    cycle(1'b1, 1'b1, 16'h0000, 1'b1);
    check("resume_halted", 32'(halted), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    expect_head("resume", 1'b1, 16'h0000, 16'h1000);

    // Wrap-around.
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    expect_head("wrap0", 1'b1, 16'hFFFE, 16'h8FFF);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    expect_head("wrap1", 1'b1, 16'h0000, 16'h1000);

    // Odd redirect target.
    cycle(1'b0, 1'b1, 16'h0011, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
`ifdef MISALIGN_TRAP_EN
    check("odd_err", 32'(misalign_err), 32'd1);
    expect_head("odd_seq", 1'b1, 16'h0004, 16'h1002);
`else
    check("odd_err", 32'(misalign_err), 32'd0);
    expect_head("odd_align", 1'b1, 16'h0010, 16'h1008);
`endif
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic        h, rv, rdy;
      logic [15:0] rpc;
      h   = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 14) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rpc[0] = 1'b0;
      cycle(h, rv, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the word-addressed instruction memory. The memory read is combinational and indexed by address[15:1].
- Fetched instructions are buffered in a small prefetch FIFO with a valid/ready handshake toward decode.
- Sits between the instruction memory and the decode stage.
- Handles branch/jump redirects, flushes and halt.

Parameters:
- ADDR_W, 16, program-counter and memory-address width in bits.
- INSTR_W, 16, instruction width in bits.
- RESET_PC, 16'h0000, first fetch address after reset; bit 0 is always 0.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, at least 2).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  byte address to instruction memory; always equals pc.
- imem_instr  in  INSTR_W  combinational read data for imem_addr.
- halt_req  in  1  stop fetching after the current cycle.
- redirect_valid  in  1  branch/jump taken; flush and load a new pc.
- redirect_pc  in  ADDR_W  redirect target byte address.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  decode accepts the head entry this cycle.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  byte address of the head instruction.
- halted  out  1  high while in the HALTED state.
- misalign_err  out  1  sticky misaligned-redirect flag (only when MISALIGN_TRAP_EN is defined; otherwise tied to 0).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, FIFO count=0, pointers=0, state=BOOT.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, halted=0, misalign_err=0.
- Reset asserted mid-operation clears everything immediately. No partial entry survives.
- States:
  - BOOT: one cycle after reset release, no fetch. Always transitions to RUN.
  - RUN: normal fetching.
  - HALTED: no fetching; the FIFO still drains to decode.
- Pop: occurs when out_valid && out_ready. out_valid = (count != 0). out_instr and out_pc come directly from the head entry, registered in the FIFO with no combinational path from imem_instr.
- Push (fetch): occurs in RUN when !halt_req && !redirect_valid && (count < FIFO_DEPTH || pop).
  - Writes {pc, imem_instr} at the tail.
  - pc <= pc + 2, modulo 2^ADDR_W, so 16'hFFFE wraps to 16'h0000.
- Simultaneous push and pop when full: allowed, count is unchanged.
- Latency: with out_ready=1 and no redirect, one instruction is delivered per cycle. The first out_valid appears 2 cycles after rst_n rises (BOOT cycle, then the push cycle). The entry is visible the cycle after its push.
- Redirect (highest priority, any state except BOOT):
  - FIFO is flushed: count=0, pointers reset.
  - Any pop that cycle is discarded.
  - No push that cycle.
  - pc <= {redirect_pc[ADDR_W-1:1], 1'b0}.
  - State <= RUN, which also exits HALTED.
  - out_valid is 0 in the following cycle; the new target is pushed in that cycle and appears one cycle later.
- halt_req in RUN (without redirect): state <= HALTED, no push that cycle, pc holds.
- halt_req in HALTED: no effect.
- redirect_valid and halt_req in the same cycle: redirect wins; halt_req is ignored.
- halted = (state == HALTED), registered.
- imem_addr = pc in every state.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect with redirect_pc[0]=1 does not flush the FIFO and does not change pc or state; misalign_err is set and stays 1 until reset.
- Not defined: bit 0 is silently cleared, the redirect proceeds normally, and misalign_err is constant 0.

Test Plan:
1. Reset release; memory word k = 16'h1000+k; out_ready=1.
   - out_valid rises 2 cycles after rst_n rises.
   - Then (out_pc, out_instr) = (0,1000), (2,1001), (4,1002), one per cycle.
2. out_ready=0 for 5 cycles after start.
   - count saturates at 2 and pc stops at 16'h0004.
   - With out_ready back at 1, the outputs are pc 0, 2, 4 in order with no loss or duplicate.
3. Redirect to 16'h0020 while FIFO full with out_ready=1.
   - Next cycle out_valid=0.
   - Following cycle out_pc=16'h0020, out_instr=word 16.
4. halt_req pulse at pc=16'h0006.
   - halted=1 the next cycle and imem_addr stays 16'h0006.
   - FIFO drains, then out_valid=0.
   - A redirect to 16'h0000 clears halted and resumes fetch at 0.
5. Redirect to 16'hFFFE.
   - Deliveries show out_pc 16'hFFFE, then 16'h0000 (wrap).
6. Redirect to 16'h0011.
   - Without MISALIGN_TRAP_EN: fetch resumes at 16'h0010.
   - With MISALIGN_TRAP_EN: misalign_err=1 and the stream continues sequentially without a flush.
   - Asserting rst_n=0 mid-stream clears out_valid and misalign_err immediately.
